// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks destination registers of in-flight long-latency
// operations (mul/div, cache-miss loads) and holds decode while an operand
// or destination is still waiting on an out-of-band writeback. It also caps
// the number of long operations in flight.
module reg_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_long,
    input  logic             id_flush,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    output logic             stall,
    output logic             issue,
    output logic [CNT_W-1:0] outstanding,
    output logic             full,
    output logic             err
);

    // Register indices are 5 bits wide, so the lookup vector always spans
    // 32 entries; entries that do not exist read back as "not pending".
    localparam int IDX_W = 5;
    localparam int IDX_N = 1 << IDX_W;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:1] pending_q;
    logic [NUM_REGS-1:1] pending_d;
    logic [CNT_W-1:0]    outstanding_q;
    logic [CNT_W-1:0]    outstanding_d;
    logic                err_q;
    logic                err_d;

    // Full-width pending view with x0 and out-of-range entries tied low.
    logic [IDX_N-1:0]    pend_vec;

    // Decode-side hazard terms.
    logic                decode_live;
    logic                rs1_hit;
    logic                rs2_hit;
    logic                waw_hit;
    logic                cap_hit;
    logic                full_w;

    // Writeback protocol checks.
    logic                wb_underflow;
    logic                wb_unmatched;
    logic                wb_dec;

    // ------------------------------------------------------------------
    // Pending lookup vector
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < IDX_N; gi++) begin : g_pend_vec
            if (gi == 0 || gi >= NUM_REGS) begin : g_zero
                assign pend_vec[gi] = 1'b0;
            end else begin : g_live
                assign pend_vec[gi] = pending_q[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard detection (registered state only; no writeback bypass)
    // ------------------------------------------------------------------
    assign full_w      = (outstanding_q == CNT_MAX);

    // Reset and flush both suppress any decode-side action this cycle.
    assign decode_live = id_valid && !id_flush && !rst;

    assign rs1_hit     = id_uses_rs1 && pend_vec[id_rs1];
    assign rs2_hit     = id_uses_rs2 && pend_vec[id_rs2];
    assign waw_hit     = id_long && (id_rd != '0) && pend_vec[id_rd];
    assign cap_hit     = id_long && full_w;

    assign stall       = decode_live && (rs1_hit || rs2_hit || waw_hit || cap_hit);
    assign issue       = decode_live && id_long && !stall;

    // ------------------------------------------------------------------
    // Writeback checks
    // ------------------------------------------------------------------
    // A writeback with nothing in flight must not wrap the counter.
    assign wb_underflow = wb_valid && (outstanding_q == '0);
    // A writeback to a register that is not pending; this also covers an
    // issue and writeback landing on the same rd in one cycle, since the
    // WAW check only lets that happen when the bit was clear.
    assign wb_unmatched = wb_valid && (wb_rd != '0) && !pend_vec[wb_rd];
    assign wb_dec       = wb_valid && !wb_underflow;

    // ------------------------------------------------------------------
    // Per-register next state: issue sets, writeback clears, set wins
    // ------------------------------------------------------------------
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_pend_next
            logic set_hit;
            logic clr_hit;
            assign set_hit       = issue && (id_rd == IDX_W'(gi));
            assign clr_hit       = wb_valid && (wb_rd == IDX_W'(gi));
            assign pending_d[gi] = set_hit ? 1'b1 :
                                   clr_hit ? 1'b0 : pending_q[gi];
        end
    endgenerate

    // Outstanding counter and sticky error next state.
    always_comb begin
        outstanding_d = outstanding_q;
        err_d         = err_q;
        case ({issue, wb_dec})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
        if (wb_underflow || wb_unmatched) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign outstanding = outstanding_q;
    assign full        = full_w;
    assign err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a table of vectors with expected
// combinational outputs checked mid-cycle and expected registered outputs
// queued and checked after the following clock edge.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       id_long;
    logic       id_flush;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       stall;
    logic       issue;
    logic [3:0] outstanding;
    logic       full;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       r;
        logic       vld;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       lng;
        logic       fl;
        logic       wbv;
        logic [4:0] wbrd;
        logic       e_stall;
        logic       e_issue;
        logic [3:0] e_out;
        logic       e_full;
        logic       e_err;
    } vec_t;

    typedef struct {
        logic [3:0] out;
        logic       full;
        logic       err;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    reg_scoreboard #(
        .NUM_REGS       (32),
        .MAX_OUTSTANDING(4),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .id_long    (id_long),
        .id_flush   (id_flush),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .stall      (stall),
        .issue      (issue),
        .outstanding(outstanding),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic vld,
                                input int rs1, input logic u1,
                                input int rs2, input logic u2,
                                input int rd, input logic lng, input logic fl,
                                input logic wbv, input int wbrd,
                                input logic es, input logic ei, input int eo,
                                input logic ef, input logic ee);
        vec_t v;
        v.r = r;        v.vld = vld;
        v.rs1 = 5'(rs1); v.u1 = u1;
        v.rs2 = 5'(rs2); v.u2 = u2;
        v.rd = 5'(rd);  v.lng = lng; v.fl = fl;
        v.wbv = wbv;    v.wbrd = 5'(wbrd);
        v.e_stall = es; v.e_issue = ei; v.e_out = 4'(eo);
        v.e_full = ef;  v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input int tag,
                         input logic [3:0] act, input logic [3:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, tag, act, want);
        end
    endtask

    // Drive one cycle of stimulus, check combinational outputs, then check
    // the registered outputs after the edge against the queued expectation.
    task automatic apply(input vec_t v, input int tag);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = v.r;          id_valid = v.vld;
        id_rs1 = v.rs1;     id_uses_rs1 = v.u1;
        id_rs2 = v.rs2;     id_uses_rs2 = v.u2;
        id_rd = v.rd;       id_long = v.lng;   id_flush = v.fl;
        wb_valid = v.wbv;   wb_rd = v.wbrd;
        #1;
        check("stall", tag, {3'b0, stall}, {3'b0, v.e_stall});
        check("issue", tag, {3'b0, issue}, {3'b0, v.e_issue});
        e.out = v.e_out; e.full = v.e_full; e.err = v.e_err; e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty vec=%0d got=0 want=1", tag);
        end else begin
            g = sb_q.pop_front();
            check("outstanding", g.tag, outstanding, g.out);
            check("full", g.tag, {3'b0, full}, {3'b0, g.full});
            check("err", g.tag, {3'b0, err}, {3'b0, g.err});
        end
        $display("vec %0d: stall=%0b issue=%0b outstanding=%0d full=%0b err=%0b",
                 tag, v.e_stall, v.e_issue, outstanding, full, err);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_long = 1'b0;
        id_flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;

        //          r vld rs1 u1 rs2 u2 rd lng fl wbv wbrd  stl iss out ful err
        vecs.push_back(mk(1,1, 0,0, 0,0, 5,1,0, 0, 0,  0,0,0,0,0)); // 0 reset gates issue
        vecs.push_back(mk(0,1, 0,0, 0,0, 5,1,0, 0, 0,  0,1,1,0,0)); // 1 issue rd5
        vecs.push_back(mk(0,1, 5,1, 0,0, 0,0,0, 0, 0,  1,0,1,0,0)); // 2 RAW rs1=5
        vecs.push_back(mk(0,1, 0,0, 5,1, 0,0,0, 1, 5,  1,0,0,0,0)); // 3 wb no bypass
        vecs.push_back(mk(0,1, 0,0, 5,1, 0,0,0, 0, 0,  0,0,0,0,0)); // 4 released
        vecs.push_back(mk(0,1, 0,0, 0,0, 1,1,0, 0, 0,  0,1,1,0,0)); // 5
        vecs.push_back(mk(0,1, 0,0, 0,0, 2,1,0, 0, 0,  0,1,2,0,0)); // 6
        vecs.push_back(mk(0,1, 0,0, 0,0, 3,1,0, 0, 0,  0,1,3,0,0)); // 7
        vecs.push_back(mk(0,1, 0,0, 0,0, 4,1,0, 0, 0,  0,1,4,1,0)); // 8 full
        vecs.push_back(mk(0,1, 0,0, 0,0, 6,1,0, 1, 1,  1,0,3,0,0)); // 9 cap stall + wb1
        vecs.push_back(mk(0,1, 0,0, 0,0, 6,1,0, 0, 0,  0,1,4,1,0)); // 10 5th issues
        vecs.push_back(mk(0,1, 3,1, 0,0, 0,0,0, 1, 2,  1,0,3,0,0)); // 11
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 3,  0,0,2,0,0)); // 12
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 4,  0,0,1,0,0)); // 13
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 6,  0,0,0,0,0)); // 14
        vecs.push_back(mk(0,1, 0,0, 0,0, 0,1,0, 0, 0,  0,1,1,0,0)); // 15 rd=0 counts
        vecs.push_back(mk(0,1, 0,1, 0,1, 0,0,0, 0, 0,  0,0,1,0,0)); // 16 x0 never pending
        vecs.push_back(mk(0,1, 0,1, 0,0, 0,1,0, 0, 0,  0,1,2,0,0)); // 17
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 0,  0,0,1,0,0)); // 18 wb x0 ok
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 0,  0,0,0,0,0)); // 19
        vecs.push_back(mk(0,1, 0,0, 0,0, 9,1,1, 0, 0,  0,0,0,0,0)); // 20 flush
        vecs.push_back(mk(0,1, 9,1, 0,0, 0,0,0, 0, 0,  0,0,0,0,0)); // 21 no state change
        vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0, 0, 0,  0,1,1,0,0)); // 22 issue rd7
        vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0, 0, 0,  1,0,1,0,0)); // 23 WAW
        vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,1, 0, 0,  0,0,1,0,0)); // 24 flush hides stall
        vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0, 1, 7,  1,0,0,0,0)); // 25 wb7 same cycle
        vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0, 0, 0,  0,1,1,0,0)); // 26 now issues
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 7,  0,0,0,0,0)); // 27
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 3,  0,0,0,0,1)); // 28 underflow
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 0,  0,0,0,0,1)); // 29 sticky
        vecs.push_back(mk(0,1, 0,0, 0,0,10,1,0, 0, 0,  0,1,1,0,1)); // 30
        vecs.push_back(mk(0,1, 0,0, 0,0,11,1,0, 0, 0,  0,1,2,0,1)); // 31
        vecs.push_back(mk(0,1, 0,0, 0,0,12,1,0, 0, 0,  0,1,3,0,1)); // 32
        vecs.push_back(mk(1,1,10,1, 0,0,13,1,0, 0, 0,  0,0,0,0,0)); // 33 reset mid-op
        vecs.push_back(mk(0,1,10,1,11,1, 0,0,0, 0, 0,  0,0,0,0,0)); // 34 pending cleared
        vecs.push_back(mk(0,1, 0,0, 0,0,12,1,0, 0, 0,  0,1,1,0,0)); // 35
        vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 1, 5,  0,0,0,0,1)); // 36 wb unmatched rd
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0, 0,  0,0,0,0,0)); // 37
        vecs.push_back(mk(0,1, 0,0, 0,0,20,1,0, 0, 0,  0,1,1,0,0)); // 38
        vecs.push_back(mk(0,1, 0,0, 0,0,21,1,0, 1,21,  0,1,1,0,1)); // 39 same rd, set wins
        vecs.push_back(mk(0,1,21,1, 0,0, 0,0,0, 0, 0,  1,0,1,0,1)); // 40 rd21 still pending
        vecs.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0, 0,  0,0,0,0,0)); // 41
        vecs.push_back(mk(0,1,20,1,21,1, 0,0,0, 0, 0,  0,0,0,0,0)); // 42

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_outstanding", -1, outstanding, 4'd0);
        check("reset_full", -1, {3'b0, full}, 4'd0);
        check("reset_err", -1, {3'b0, err}, 4'd0);
        check("reset_stall", -1, {3'b0, stall}, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Saturation: fill, hammer with long ops while full, then drain.
        for (int i = 1; i <= 4; i++) begin
            apply(mk(0,1, 0,0, 0,0, i,1,0, 0,0, 0,1, i, (i == 4), 0), 100 + i);
        end
        for (int k = 0; k < 3; k++) begin
            apply(mk(0,1, 0,0, 0,0, 24 + k,1,0, 0,0, 1,0, 4, 1, 0), 110 + k);
        end
        for (int i = 1; i <= 4; i++) begin
            apply(mk(0,0, 0,0, 0,0, 0,0,0, 1,i, 0,0, 4 - i, 0, 0), 120 + i);
        end
        apply(mk(0,1, 1,1, 4,1, 24,1,0, 0,0, 0,1, 1, 0, 0), 130);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks destination registers of issued long-latency operations (multi-cycle mul/div, cache-miss loads) until their writeback.
- Sits beside the decode stage. It is the producer-side counterpart to operand forwarding:
  - forwarding resolves hazards for results that are already in the pipeline;
  - this block holds decode (stall) while a source or destination register is still awaiting an out-of-band result.
- Also limits the number of outstanding long-latency operations.

Parameters:
- NUM_REGS, 32, number of architectural registers; index 0 is hardwired zero.
- MAX_OUTSTANDING, 4, maximum number of in-flight long-latency ops; range 1..15.
- CNT_W, 4, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- id_valid, input, 1, a valid instruction is present in decode.
- id_rs1, input, 5, source register 1 index.
- id_rs2, input, 5, source register 2 index.
- id_rd, input, 5, destination register index.
- id_uses_rs1, input, 1, instruction reads rs1.
- id_uses_rs2, input, 1, instruction reads rs2.
- id_long, input, 1, instruction is a long-latency op that writes rd out-of-band.
- id_flush, input, 1, decode is squashed this cycle; no issue may occur.
- wb_valid, input, 1, a long-latency result is written back this cycle.
- wb_rd, input, 5, destination index of that writeback.
- stall, output, 1, hold decode (combinational).
- issue, output, 1, long op accepted this cycle (combinational).
- outstanding, output, CNT_W, number of in-flight long ops (registered).
- full, output, 1, outstanding == MAX_OUTSTANDING (registered-derived).
- err, output, 1, sticky protocol error flag (registered).

Behaviour:
- State:
  - pending[NUM_REGS-1:1], one bit per register; pending[0] does not exist and always reads 0.
  - outstanding counter.
  - err flag.
- Reset (rst=1 at a clock edge): all pending bits 0, outstanding 0, err 0. Therefore full=0, and stall=0 and issue=0 for any inputs. Reset takes priority over every other update on that edge.
- stall is combinational, computed from registered state only; a writeback in the same cycle does not bypass into stall. stall = id_valid && !id_flush && any of:
  - (a) id_uses_rs1 && pending[id_rs1];
  - (b) id_uses_rs2 && pending[id_rs2];
  - (c) id_long && id_rd!=0 && pending[id_rd] (WAW hazard);
  - (d) id_long && full.
- issue = id_valid && id_long && !id_flush && !stall.
- Register index 0 is never pending, so reads and writes of x0 never cause a stall.
- On an edge with issue=1:
  - pending[id_rd] is set when id_rd != 0;
  - outstanding is incremented even when id_rd == 0, because the functional unit is still occupied.
- On an edge with wb_valid=1:
  - pending[wb_rd] is cleared (no effect when wb_rd == 0);
  - outstanding is decremented.
- Issue and writeback on the same edge:
  - outstanding is unchanged;
  - set and clear target different registers, because the WAW check forbids issuing to a pending rd;
  - if both target the same register (only possible when the bit was clear, i.e. a protocol violation), the set wins and err is set.
- Protocol errors set err, which stays 1 until reset:
  - wb_valid while outstanding == 0: the counter holds at 0; no underflow.
  - wb_valid with wb_rd != 0 and pending[wb_rd] == 0.
- Saturation: issue cannot occur while full, so outstanding never exceeds MAX_OUTSTANDING.
- Flush: id_flush forces stall=0 and issue=0 for that cycle. Pending bits and outstanding are untouched, because operations already issued always complete and write back.
- Latency:
  - a register becomes pending the cycle after issue;
  - a register is released the cycle after its writeback, so a dependent instruction stalls for exactly one extra cycle after wb_valid.

Test Plan:
- Reset, then id_valid=1, id_long=1, id_rd=5 -> issue=1 that cycle; next cycle outstanding=1, pending[5]=1. Then id_uses_rs1=1, id_rs1=5 -> stall=1.
- Writeback clears a hazard: with pending[5]=1, apply wb_valid=1, wb_rd=5 while decode reads rs2=5 -> stall=1 in that cycle, stall=0 the next cycle, outstanding=0.
- Outstanding limit: issue 4 long ops to rd=1,2,3,4 on consecutive cycles -> full=1, outstanding=4. A 5th long op to rd=6 -> stall=1. Same cycle wb_rd=1 -> next cycle full=0 and the 5th op issues; outstanding=4.
- x0 and flush:
  - a long op with rd=0 -> outstanding increments with no pending bit, and a later read of rs1=0 gives stall=0;
  - a long op with id_flush=1 -> issue=0 and state unchanged.
- WAW: pending[7]=1 and a long op with rd=7 -> stall=1 until the cycle after wb_rd=7.
- Errors and reset:
  - wb_valid with outstanding=0 -> err=1 and outstanding stays 0;
  - rst asserted mid-operation with 3 ops outstanding -> next cycle outstanding=0, all pending bits clear, err=0.
